// File: rtl/imem_load_pkg.sv
// Shared definitions for the instruction-memory loader.
// The optional checksum feature is selected with the IMEM_LOAD_CSUM_EN macro.
package imem_load_pkg;

  localparam int unsigned IMEM_WORDS_DEF = 128;
  localparam int unsigned AW_DEF         = 7;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCount  = 3'd1,
    StHi     = 3'd2,
    StLo     = 3'd3,
    StWrite  = 3'd4,
    StCsum   = 3'd5,
    StFinish = 3'd6,
    StFail   = 3'd7
  } state_e;

endpackage

// File: rtl/imem_word_asm.sv
// Byte-pair to 16-bit word assembler for the instruction-memory loader.
// With IMEM_LOAD_CSUM_EN defined it also keeps an XOR checksum of every data byte.
module imem_word_asm (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_hi_en,
  input  logic        i_lo_en,
  input  logic [7:0]  i_byte,
`ifdef IMEM_LOAD_CSUM_EN
  output logic [7:0]  o_csum,
`endif
  output logic [15:0] o_word
);

  logic [7:0]  r_hi;
  logic [15:0] r_word;

  // High byte is parked until its low partner arrives; the word updates only then,
  // so the output holds the last written word between writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi   <= 8'h00;
      r_word <= 16'h0000;
    end else begin
      if (i_hi_en) r_hi   <= i_byte;
      if (i_lo_en) r_word <= {r_hi, i_byte};
    end
  end

  assign o_word = r_word;

`ifdef IMEM_LOAD_CSUM_EN
  logic [7:0] r_csum;

  // Running XOR over all data bytes of the current load; cleared when a load starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= 8'h00;
    end else if (i_clr) begin
      r_csum <= 8'h00;
    end else if (i_hi_en || i_lo_en) begin
      r_csum <= r_csum ^ i_byte;
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: takes a byte stream (count, then hi/lo byte pairs)
// and writes 16-bit words into instruction memory while holding the CPU.
// Optional trailing checksum byte is enabled with the IMEM_LOAD_CSUM_EN macro.
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int unsigned AW         = AW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          IN_VALID,
  input  logic [7:0]    IN_DATA,
  output logic          IN_READY,
  output logic          WE,
  output logic [AW-1:0] WADDR,
  output logic [15:0]   WDATA,
  output logic          CPU_HOLD,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  // One extra bit so a full-depth count fits without wrapping.
  localparam int unsigned CW = AW + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  logic [AW-1:0] r_waddr;
  logic [CW-1:0] w_count_val;
  logic          w_ready;
  logic          w_busy;
  logic          w_accept;
  logic          w_start;
  logic          w_last;
  logic          w_hi_en;
  logic          w_lo_en;
  logic [15:0]   w_word;

  assign w_ready  = (r_state == StCount) || (r_state == StHi) ||
                    (r_state == StLo)    || (r_state == StCsum);
  assign w_busy   = w_ready || (r_state == StWrite);
  assign w_accept = IN_VALID && w_ready;
  // Non-busy states are exactly IDLE, FINISH and FAIL, so START is honoured only there.
  assign w_start  = START && !w_busy;
  assign w_last   = ((r_idx + CW'(1)) == r_count);
  assign w_hi_en  = w_accept && (r_state == StHi);
  assign w_lo_en  = w_accept && (r_state == StLo);

  // Word count from the header byte: zero means full depth, oversize is clamped.
  always_comb begin
    w_count_val = CW'(IN_DATA);
    if ((IN_DATA == 8'h00) || ({24'h0, IN_DATA} > IMEM_WORDS)) begin
      w_count_val = CW'(IMEM_WORDS);
    end
  end

`ifdef IMEM_LOAD_CSUM_EN
  logic [7:0] w_csum;

  imem_word_asm u_asm (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_clr   (w_start),
    .i_hi_en (w_hi_en),
    .i_lo_en (w_lo_en),
    .i_byte  (IN_DATA),
    .o_csum  (w_csum),
    .o_word  (w_word)
  );
`else
  imem_word_asm u_asm (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_clr   (w_start),
    .i_hi_en (w_hi_en),
    .i_lo_en (w_lo_en),
    .i_byte  (IN_DATA),
    .o_word  (w_word)
  );
`endif

  // Next-state decode; every data-taking state stalls while no byte is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StFinish, StFail: if (w_start) w_state_nxt = StCount;
      StCount:                  if (w_accept) w_state_nxt = StHi;
      StHi:                     if (w_accept) w_state_nxt = StLo;
      StLo:                     if (w_accept) w_state_nxt = StWrite;
      StWrite: begin
        if (!w_last) begin
          w_state_nxt = StHi;
        end else begin
`ifdef IMEM_LOAD_CSUM_EN
          w_state_nxt = StCsum;
`else
          w_state_nxt = StFinish;
`endif
        end
      end
`ifdef IMEM_LOAD_CSUM_EN
      StCsum: if (w_accept) w_state_nxt = (IN_DATA == w_csum) ? StFinish : StFail;
`endif
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, word counter, target count and write address.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_count <= '0;
      r_idx   <= '0;
      r_waddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) r_idx <= '0;
      else if (r_state == StWrite) r_idx <= r_idx + CW'(1);
      if (w_accept && (r_state == StCount)) r_count <= w_count_val;
      // Address is captured alongside the word so both hold steady outside WRITE.
      if (w_lo_en) r_waddr <= r_idx[AW-1:0];
    end
  end

  assign IN_READY = w_ready;
  assign WE       = (r_state == StWrite);
  assign WADDR    = r_waddr;
  assign WDATA    = w_word;
  assign BUSY     = w_busy;
  assign CPU_HOLD = w_busy || (r_state == StFail);
  assign DONE     = (r_state == StFinish);
`ifdef IMEM_LOAD_CSUM_EN
  assign ERR      = (r_state == StFail);
`else
  assign ERR      = 1'b0;
`endif

endmodule
